// File: rtl/guess_round_ctrl.sv
`timescale 1ns/1ps
// guess_round_ctrl: round sequencer for the LED-guessing game (FSM, phase timers, score counters)
//   CLK        in   system clock
//   RST        in   asynchronous active-low reset
//   tick       in   one-cycle enable pulse from the clock divider
//   key_n      in   raw active-low button, asynchronous to CLK
//   match      in   comparator result, used in EVAL only
//   pat_load   out  one-cycle pulse on the first SHOW cycle
//   leds_show  out  high throughout SHOW
//   reveal_on  out  REVEAL blink phase (timer bit 2)
//   score_upd  out  one-cycle pulse on the first REVEAL cycle
//   rounds     out  rounds played (saturating at 15)
//   rounds_ok  out  rounds guessed correctly (saturating at 15)
//   game_over  out  high in DONE
//   state_oh   out  one-hot state, bit n = state n
// Optional: GUESS_ROUND_CTRL_DIFFICULTY_EN shortens SHOW by one tick per correct round, floored at 1.
module guess_round_ctrl #(
   parameter int SHOW_TICKS        = 5,
   parameter int GUESS_TICKS       = 500,
   parameter int REVEAL_FAIL_TICKS = 96,
   parameter int REVEAL_PASS_TICKS = 48,
   parameter int MAX_ROUNDS        = 8
) (
   input  logic       CLK,
   input  logic       RST,
   input  logic       tick,
   input  logic       key_n,
   input  logic       match,
   output logic       pat_load,
   output logic       leds_show,
   output logic       reveal_on,
   output logic       score_upd,
   output logic [3:0] rounds,
   output logic [3:0] rounds_ok,
   output logic       game_over,
   output logic [5:0] state_oh
);
   typedef enum logic [2:0] {IDLE, SHOW, GUESS, EVAL, REVEAL, DONE} state_t;
   state_t      state_q, state_d;
   logic [15:0] timer_q, timer_d, show_len;
   logic [3:0]  rounds_q, rounds_d, ok_q, ok_d;
   logic        k1_q, k2_q, k3_q, press;
   logic        pat_load_q, leds_show_q, reveal_on_q, score_upd_q, game_over_q;
   logic [5:0]  state_oh_q;

   // falling edge of the synchronised key: k3 still released, k2 already pressed
   assign press = k3_q & ~k2_q;

`ifdef GUESS_ROUND_CTRL_DIFFICULTY_EN
   logic [15:0] show_len_q, show_len_d;
   assign show_len_d = (state_q == EVAL && match && show_len_q > 16'd1) ? show_len_q - 16'd1 : show_len_q;
   assign show_len   = show_len_q;
   always_ff @(posedge CLK or negedge RST)
      if (!RST) show_len_q <= 16'(SHOW_TICKS);
      else      show_len_q <= show_len_d;
`else
   assign show_len = 16'(SHOW_TICKS);
`endif

   always_comb begin
      state_d  = state_q;
      timer_d  = timer_q;
      rounds_d = rounds_q;
      ok_d     = ok_q;
      unique case (state_q)
         IDLE: if (press) begin
            state_d = SHOW;
            timer_d = show_len;
         end
         SHOW: if (tick) begin
            state_d = timer_q == 16'd0 ? GUESS : SHOW;
            timer_d = timer_q == 16'd0 ? 16'(GUESS_TICKS) : timer_q - 16'd1;
         end
         GUESS: if (press) state_d = EVAL;
            else if (tick) begin
               state_d = timer_q == 16'd0 ? EVAL : GUESS;
               timer_d = timer_q == 16'd0 ? timer_q : timer_q - 16'd1;
            end
         EVAL: begin
            state_d  = REVEAL;
            rounds_d = rounds_q + 4'(rounds_q != 4'd15);
            ok_d     = ok_q + 4'(match && ok_q != 4'd15);
            timer_d  = match ? 16'(REVEAL_PASS_TICKS) : 16'(REVEAL_FAIL_TICKS);
         end
         REVEAL: if (tick) begin
            state_d = timer_q != 16'd0 ? REVEAL : (rounds_q == 4'(MAX_ROUNDS) ? DONE : IDLE);
            timer_d = timer_q == 16'd0 ? timer_q : timer_q - 16'd1;
         end
         default: ;
      endcase
   end

   // outputs are computed from next-state values so they line up with the state register
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         {k3_q, k2_q, k1_q} <= 3'b111;
         state_q     <= IDLE;
         timer_q     <= '0;
         rounds_q    <= '0;
         ok_q        <= '0;
         pat_load_q  <= 1'b0;
         leds_show_q <= 1'b0;
         reveal_on_q <= 1'b0;
         score_upd_q <= 1'b0;
         game_over_q <= 1'b0;
         state_oh_q  <= 6'b000001;
      end else begin
         {k3_q, k2_q, k1_q} <= {k2_q, k1_q, key_n};
         state_q     <= state_d;
         timer_q     <= timer_d;
         rounds_q    <= rounds_d;
         ok_q        <= ok_d;
         pat_load_q  <= state_d == SHOW && state_q != SHOW;
         leds_show_q <= state_d == SHOW;
         reveal_on_q <= state_d == REVEAL && timer_d[2];
         score_upd_q <= state_q == EVAL;
         game_over_q <= state_d == DONE;
         state_oh_q  <= 6'd1 << state_d;
      end
   end

   assign pat_load  = pat_load_q;
   assign leds_show = leds_show_q;
   assign reveal_on = reveal_on_q;
   assign score_upd = score_upd_q;
   assign rounds    = rounds_q;
   assign rounds_ok = ok_q;
   assign game_over = game_over_q;
   assign state_oh  = state_oh_q;
endmodule
